register_file_sb: RTL and testbench

- Parametrised successor to the single-cycle datapath's 2-read/1-write register file.
- Configurable data width, address width and number of read ports.
- Asynchronous clear of the whole array.
- Optional write-to-read bypass.
- Per-register busy scoreboard: an issuing instruction reserves its destination, and the writeback that produces the value releases it.
- Serves the pipelined datapath: decode reads operands and busy flags, writeback writes results.

---
 rtl/register_file_sb_pkg.sv | 25 ++
 rtl/register_file_sb_if.sv | 33 +++
 rtl/register_file_sb_scoreboard.sv | 55 +++++
 rtl/register_file_sb.sv | 91 +++++++++
 tb/tb_register_file_sb.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_sb_pkg.sv
// regfile_pkg: shared constants and helpers for the scoreboarded register file.
//   REG_N     default data width
//   REG_RN    default address width (2**REG_RN registers)
//   ZERO_REG  index of the hardwired-zero register
//   popcount  counts set bits of a busy vector (zero-extended to POP_MAX bits)
package regfile_pkg;

  localparam int REG_N  = 32;
  localparam int REG_RN = 5;

  localparam int unsigned ZERO_REG = 0;

  // Widest busy vector popcount accepts; supports RN up to 10.
  localparam int POP_MAX = 1024;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// register_file_sb_if: bus between the pipeline and the register file.
//   master (pipeline): drives regWrite/A3/WD (writeback), resv/resvAddr (issue),
//                      RA (decode); receives RD, RBusy, busyCount.
//   slave  (register file): the opposite directions.
interface register_file_sb_if
  import regfile_pkg::*;
#(
  parameter int N   = REG_N,
  parameter int RN  = REG_RN,
  parameter int NRP = 2
);

  logic              regWrite;
  logic [RN-1:0]     A3;
  logic [N-1:0]      WD;
  logic              resv;
  logic [RN-1:0]     resvAddr;
  logic [NRP*RN-1:0] RA;
  logic [NRP*N-1:0]  RD;
  logic [NRP-1:0]    RBusy;
  logic [RN:0]       busyCount;

  modport master (
    output regWrite, A3, WD, resv, resvAddr, RA,
    input  RD, RBusy, busyCount
  );

  modport slave (
    input  regWrite, A3, WD, resv, resvAddr, RA,
    output RD, RBusy, busyCount
  );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// regfile_scoreboard: per-register busy bits and registered busy count.
//   clk, rst    clock and asynchronous active-high reset
//   wr_en       writeback to a nonzero register this cycle (releases wr_addr)
//   wr_addr     writeback destination
//   resv        reserve request from issue
//   resv_addr   register to mark busy
//   busy        current busy vector (bit 0 always 0)
//   busy_count  number of busy registers, updated with the busy bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int RN = REG_RN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [RN-1:0]        wr_addr,
  input  logic                 resv,
  input  logic [RN-1:0]        resv_addr,
  output logic [(1<<RN)-1:0]   busy,
  output logic [RN:0]          busy_count
);

  localparam int NREG = 1 << RN;

  logic [NREG-1:0] busy_q, busy_d;
  logic [RN:0]     busy_count_q, busy_count_d;

  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    // Reserve is applied after release so a same-edge new producer wins.
    if (resv && (resv_addr != RN'(ZERO_REG))) begin
      busy_d[resv_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
    busy_count_d = (RN+1)'(popcount(POP_MAX'(busy_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = busy_count_q;

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: 2**RN x N register file with NRP combinational read ports,
// one write port, optional write-to-read bypass and a busy scoreboard.
//   clk, rst  clock and asynchronous active-high reset (clears data and busy)
//   bus       slave side of register_file_sb_if:
//             regWrite/A3/WD  write port (register 0 ignored)
//             resv/resvAddr   reserve destination (register 0 ignored)
//             RA/RD/RBusy     packed read ports, lane i at [i*RN +: RN] / [i*N +: N] / [i]
//             busyCount       registered number of busy registers
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int N      = REG_N,
  parameter int RN     = REG_RN,
  parameter int NRP    = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  register_file_sb_if.slave    bus
);

  localparam int NREG = 1 << RN;

  logic [N-1:0]    regs_q [NREG];
  logic [N-1:0]    regs_d [NREG];
  logic [NREG-1:0] busy;
  logic            wr_en;
  logic            resv_hits_wr;

  assign wr_en        = bus.regWrite && (bus.A3 != RN'(ZERO_REG));
  assign resv_hits_wr = bus.resv && (bus.resvAddr == bus.A3);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[bus.A3] = bus.WD;
    end
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .RN(RN)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (bus.A3),
    .resv       (bus.resv),
    .resv_addr  (bus.resvAddr),
    .busy       (busy),
    .busy_count (bus.busyCount)
  );

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [RN-1:0] ra;
    logic [N-1:0]  rd;
    logic          rb;

    assign ra = bus.RA[p*RN +: RN];

    always_comb begin
      rd = regs_q[ra];
      rb = busy[ra];
      // Gate on rst so a bypassed write cannot leak through while in reset.
      if (rst || (ra == RN'(ZERO_REG))) begin
        rd = '0;
        rb = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (ra == bus.A3)) begin
        rd = bus.WD;
        // A same-cycle reserve of this register shows the current bit, no look-ahead.
        if (!resv_hits_wr) begin
          rb = 1'b0;
        end
      end
    end

    assign bus.RD[p*N +: N] = rd;
    assign bus.RBusy[p]     = rb;
  end

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;
  import regfile_pkg::*;

  localparam int N    = 32;
  localparam int RN   = 5;
  localparam int NRP  = 3;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_sb_if #(.N(N), .RN(RN), .NRP(NRP)) bus_b ();
  register_file_sb_if #(.N(N), .RN(RN), .NRP(NRP)) bus_n ();

  register_file_sb #(.N(N), .RN(RN), .NRP(NRP), .BYPASS(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  register_file_sb #(.N(N), .RN(RN), .NRP(NRP), .BYPASS(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.slave)
  );

  assign bus_n.regWrite = bus_b.regWrite;
  assign bus_n.A3       = bus_b.A3;
  assign bus_n.WD       = bus_b.WD;
  assign bus_n.resv     = bus_b.resv;
  assign bus_n.resvAddr = bus_b.resvAddr;
  assign bus_n.RA       = bus_b.RA;

  // Reference model: architectural register contents and busy flags.
  logic [N-1:0] m_mem  [NREG];
  bit           m_busy [NREG];

  typedef struct {
    logic [NRP*N-1:0] rd_b;
    logic [NRP*N-1:0] rd_n;
    logic [NRP-1:0]   rb_b;
    logic [NRP-1:0]   rb_n;
    logic [RN:0]      cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Apply the rules of a rising edge using the inputs present at that edge.
  function automatic void model_commit();
    int wa, ra;
    wa = int'(bus_b.A3);
    ra = int'(bus_b.resvAddr);
    if (rst) begin
      model_clear();
    end else begin
      if (bus_b.regWrite && wa != 0) begin
        m_mem[wa]  = bus_b.WD;
        m_busy[wa] = 1'b0;
      end
      if (bus_b.resv && ra != 0) m_busy[ra] = 1'b1;
    end
  endfunction

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic void push_expected();
    exp_t e;
    int a;
    for (int p = 0; p < NRP; p++) begin
      a = int'(bus_b.RA[p*RN +: RN]);
      if (rst || a == 0) begin
        e.rd_b[p*N +: N] = '0;  e.rb_b[p] = 1'b0;
        e.rd_n[p*N +: N] = '0;  e.rb_n[p] = 1'b0;
      end else begin
        e.rd_n[p*N +: N] = m_mem[a];
        e.rb_n[p]        = m_busy[a];
        if (bus_b.regWrite && a == int'(bus_b.A3)) begin
          e.rd_b[p*N +: N] = bus_b.WD;
          e.rb_b[p] = (bus_b.resv && a == int'(bus_b.resvAddr)) ? m_busy[a] : 1'b0;
        end else begin
          e.rd_b[p*N +: N] = m_mem[a];
          e.rb_b[p]        = m_busy[a];
        end
      end
    end
    e.cnt = rst ? '0 : (RN+1)'(model_count());
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_bypass",     96'(bus_b.RD),        96'(e.rd_b));
      chk("rbusy_bypass",  96'(bus_b.RBusy),     96'(e.rb_b));
      chk("count_bypass",  96'(bus_b.busyCount), 96'(e.cnt));
      chk("rd_nobypass",   96'(bus_n.RD),        96'(e.rd_n));
      chk("rbusy_nobypass",96'(bus_n.RBusy),     96'(e.rb_n));
      chk("count_nobypass",96'(bus_n.busyCount), 96'(e.cnt));
    end
  end

  function automatic logic [NRP*RN-1:0] ra3(input logic [RN-1:0] a0, input logic [RN-1:0] a1,
                                             input logic [RN-1:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic step(input logic rw, input logic [RN-1:0] a3, input logic [N-1:0] wd,
                      input logic rs, input logic [RN-1:0] raddr, input logic [NRP*RN-1:0] ra);
    @(posedge clk);
    #1;
    model_commit();
    bus_b.regWrite = rw;
    bus_b.A3       = a3;
    bus_b.WD       = wd;
    bus_b.resv     = rs;
    bus_b.resvAddr = raddr;
    bus_b.RA       = ra;
    push_expected();
  endtask

  // Change rst between edges; the model clears at once because reset is asynchronous.
  task automatic set_rst(input logic v);
    @(posedge clk);
    #1;
    model_commit();
    rst = v;
    if (v) model_clear();
    push_expected();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus_b.regWrite = 1'b0;
    bus_b.A3       = '0;
    bus_b.WD       = '0;
    bus_b.resv     = 1'b0;
    bus_b.resvAddr = '0;
    bus_b.RA       = '0;
    model_clear();

    step(0, 0, 0, 0, 0, ra3(5, 6, 0));
    set_rst(0);

    // Reset clears everything, mid-cycle.
    step(1, 5, 32'hDEAD_BEEF, 0, 0, ra3(5, 5, 5));
    step(0, 0, 0, 1, 6, ra3(5, 6, 6));
    step(0, 0, 0, 0, 0, ra3(5, 6, 0));
    step(1, 8, 32'h0000_7777, 1, 6, ra3(5, 6, 8));
    set_rst(1);
    step(1, 8, 32'h0000_7777, 1, 6, ra3(5, 6, 8));
    set_rst(0);
    step(0, 0, 0, 0, 0, ra3(5, 6, 8));

    // Register 0 is inert.
    step(1, 0, 32'h1234_5678, 1, 0, ra3(0, 0, 0));
    step(0, 0, 0, 0, 0, ra3(0, 0, 0));

    // Reserve then release.
    step(0, 0, 0, 1, 7, ra3(7, 0, 0));
    step(0, 0, 0, 0, 0, ra3(7, 7, 0));
    step(1, 7, 32'h0000_00A5, 0, 0, ra3(7, 7, 7));
    step(0, 0, 0, 0, 0, ra3(7, 0, 7));

    // Simultaneous reserve and write.
    step(1, 9, 32'h0000_0055, 1, 9, ra3(9, 9, 0));
    step(0, 0, 0, 0, 0, ra3(9, 9, 9));
    // Write of a busy register while a reserve re-targets it.
    step(1, 9, 32'h0000_0066, 1, 9, ra3(9, 0, 9));
    step(0, 0, 0, 0, 0, ra3(9, 9, 9));

    // Write then read same cycle (bypass vs. next-cycle visibility).
    step(1, 3, 32'h0000_0011, 0, 0, ra3(3, 3, 3));
    step(0, 0, 0, 0, 0, ra3(3, 3, 3));

    // Multi-port read of r4 and busyCount saturating at 31.
    step(1, 4, 32'h0000_CAFE, 0, 0, ra3(4, 4, 4));
    for (int r = 1; r < NREG; r++) step(0, 0, 0, 1, RN'(r), ra3(4, 4, 4));
    step(0, 0, 0, 1, 1, ra3(4, RN'(31), 1));
    step(0, 0, 0, 1, 31, ra3(4, 4, 4));
    step(0, 0, 0, 0, 0, ra3(1, 4, 31));

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      logic [RN-1:0] a3, raddr, p0, p1, p2;
      if ($urandom_range(0, 79) == 0) begin
        set_rst(1);
        set_rst(0);
      end
      a3    = RN'($urandom_range(0, NREG-1));
      raddr = ($urandom_range(0, 3) == 0) ? a3 : RN'($urandom_range(0, NREG-1));
      p0    = ($urandom_range(0, 2) == 0) ? a3 : RN'($urandom_range(0, NREG-1));
      p1    = RN'($urandom_range(0, NREG-1));
      p2    = ($urandom_range(0, 3) == 0) ? raddr : RN'($urandom_range(0, NREG-1));
      step(1'($urandom_range(0, 1)), a3, $urandom(), 1'($urandom_range(0, 2) == 0),
           raddr, ra3(p0, p1, p2));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 96'(exp_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
